// File: rtl/inpkt_checksum_pkg.sv
// Shared definitions for the receive-side checksum verifier.
//   - header layout: word count and word offsets of the 5-word header
//   - FSM state encoding (also visible on the top-level dbg_state port)
//   - default required header version byte
package inpkt_checksum_pkg;

  localparam int HDR_WORDS        = 5;
  localparam int HDR_W_TYPE_VER   = 0;  // {type, ver}
  localparam int HDR_W_RSVD       = 1;
  localparam int HDR_W_LEN_LO     = 2;  // len[15:0]
  localparam int HDR_W_LEN_HI     = 3;  // {rsvd, len[23:16]}
  localparam int HDR_W_ID         = 4;

  localparam logic [7:0] PKT_VERSION_DEFAULT = 8'd2;

  typedef enum logic [2:0] {
    S_HDR     = 3'd0,
    S_HDR_CS0 = 3'd1,
    S_HDR_CS1 = 3'd2,
    S_HDR_OUT = 3'd3,
    S_DATA    = 3'd4,
    S_DAT_CS0 = 3'd5,
    S_DAT_CS1 = 3'd6,
    S_ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/inpkt_checksum_acc.sv
// Pair latch + 32-bit wrapping accumulator + checksum-half compare.
// Words are summed as 32-bit pairs {w[2k+1], w[2k]}; an odd trailing word
// still sitting in the pair latch is folded in zero-extended when comparing.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clear     zero the accumulator and the pair phase (wins over add)
//   add       accumulate word
//   sel_hi    compare word against the high (1) or low (0) inverted-sum half
//   word      16-bit input word
//   match     word equals the selected half of ~sum (combinational)
module inpkt_checksum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add,
  input  logic        sel_hi,
  input  logic [15:0] word,
  output logic        match
);

  logic [31:0] sum;
  logic [15:0] lo;
  logic        phase;  // 1: lo holds the first word of an open pair
  logic [31:0] total;

  assign total = sum + (phase ? {16'h0000, lo} : 32'h0000_0000);
  assign match = (word == (sel_hi ? ~total[31:16] : ~total[15:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      lo    <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      sum   <= '0;
      lo    <= '0;
      phase <= 1'b0;
    end else if (add) begin
      if (phase) begin
        sum   <= sum + {word, lo};
        phase <= 1'b0;
      end else begin
        lo    <= word;
        phase <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inpkt_checksum.sv
// Receive-side checksum verifier. Takes {header(5), hdr cksum(2), data,
// data cksum(2)} as 16-bit words, verifies both checksums, strips the
// checksum words and forwards header+data with packet-boundary flags.
// The header is held until its checksum verifies; data streams through.
// Optional build macro INPKT_CHECKSUM_INTERVAL_EN: expect an extra 2-word
// checksum after every PKT_CHECKSUM_INTERVAL data bytes (not at packet end).
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   din, wr_en, full  input write port (accepted when wr_en & ~full)
//   dout, pkt_new_out, pkt_end_out, rd_en, empty   output read port
//   err_hdr           sticky: bad version / length
//   err_checksum      sticky: header or data checksum mismatch
//   dbg_state         current FSM state (state_t encoding)
// Handshake: an input word moves on each cycle the FSM consumes it; full
// is "register occupied and not consumed this cycle", so a new word may be
// written in the same cycle the held one is consumed (1 word/clk). An
// output word is removed on rd_en & ~empty and may be replaced that cycle.
module inpkt_checksum
  import inpkt_checksum_pkg::*;
#(
  parameter logic [7:0] PKT_VERSION = PKT_VERSION_DEFAULT,
  parameter int         PKT_MAX_LEN = 16384
`ifdef INPKT_CHECKSUM_INTERVAL_EN
  , parameter int       PKT_CHECKSUM_INTERVAL = 448
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] din,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic        pkt_new_out,
  output logic        pkt_end_out,
  input  logic        rd_en,
  output logic        empty,
  output logic        err_hdr,
  output logic        err_checksum,
  output logic [2:0]  dbg_state
);

  state_t      state;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] hdr_buf [HDR_WORDS];
  logic [2:0]  idx;
  logic [22:0] dcnt;
  logic [22:0] nwords;
  logic [23:0] hdr_len;
  logic        hdr_bad;
  logic        out_free;
  logic        in_take;
  logic        out_wr;
  logic [15:0] out_wdata;
  logic        data_last;
  logic        cs_match;
  logic        acc_add;
  logic        acc_clear;
  logic        acc_sel_hi;
`ifdef INPKT_CHECKSUM_INTERVAL_EN
  localparam int INTERVAL_WORDS = PKT_CHECKSUM_INTERVAL / 2;
  logic        mid;      // checksum in progress is an intermediate one
  logic [22:0] int_cnt;
`endif

  assign out_free  = ~out_valid | rd_en;
  assign empty     = ~out_valid;
  assign full      = in_valid & ~in_take;
  assign dbg_state = state;
  assign hdr_len   = {hdr_buf[HDR_W_LEN_HI][7:0], hdr_buf[HDR_W_LEN_LO]};
  assign hdr_bad   = (hdr_buf[HDR_W_TYPE_VER][7:0] != PKT_VERSION) || (hdr_len == 24'd0)
                   || hdr_len[0] || (hdr_len > 24'(PKT_MAX_LEN));
  assign data_last = (dcnt == nwords - 23'd1);

  // Header words and checksum words never need the output register; ERR
  // discards everything; DATA can only consume when the word can be placed.
  always_comb begin
    in_take = 1'b0;
    case (state)
      S_HDR, S_HDR_CS0, S_HDR_CS1,
      S_DAT_CS0, S_DAT_CS1, S_ERR: in_take = in_valid;
      S_DATA:                      in_take = in_valid & out_free;
      default:                     in_take = 1'b0;
    endcase
  end

  always_comb begin
    out_wr    = 1'b0;
    out_wdata = in_data;
    if (state == S_HDR_OUT) begin
      out_wr    = out_free;
      out_wdata = hdr_buf[idx];
    end else if (state == S_DATA) begin
      out_wr    = in_take;
    end
  end

  assign acc_add    = in_take && (state == S_HDR || state == S_DATA);
  assign acc_clear  = in_take && (state == S_HDR_CS1 || state == S_DAT_CS1);
  assign acc_sel_hi = (state == S_HDR_CS1 || state == S_DAT_CS1);

  inpkt_checksum_acc u_acc (
    .clk    (CLK),
    .rst    (RST),
    .clear  (acc_clear),
    .add    (acc_add),
    .sel_hi (acc_sel_hi),
    .word   (in_data),
    .match  (cs_match)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_valid <= 1'b0;
      in_data  <= '0;
    end else if (wr_en && !full) begin
      in_valid <= 1'b1;
      in_data  <= din;
    end else if (in_take) begin
      in_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid   <= 1'b0;
      dout        <= '0;
      pkt_new_out <= 1'b0;
      pkt_end_out <= 1'b0;
    end else if (out_wr) begin
      out_valid   <= 1'b1;
      dout        <= out_wdata;
      pkt_new_out <= (state == S_HDR_OUT) && (idx == 3'd0);
      pkt_end_out <= (state == S_DATA) && data_last;
    end else if (rd_en) begin
      out_valid   <= 1'b0;
      pkt_new_out <= 1'b0;
      pkt_end_out <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_HDR;
      idx          <= '0;
      dcnt         <= '0;
      nwords       <= '0;
      err_hdr      <= 1'b0;
      err_checksum <= 1'b0;
      for (int i = 0; i < HDR_WORDS; i++) hdr_buf[i] <= '0;
`ifdef INPKT_CHECKSUM_INTERVAL_EN
      mid          <= 1'b0;
      int_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_HDR: if (in_take) begin
          hdr_buf[idx] <= in_data;
          if (idx == 3'(HDR_WORDS - 1)) begin
            idx   <= '0;
            state <= S_HDR_CS0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_HDR_CS0: if (in_take) begin
          if (!cs_match) begin
            err_checksum <= 1'b1;
            state        <= S_ERR;
          end else begin
            state <= S_HDR_CS1;
          end
        end
        S_HDR_CS1: if (in_take) begin
          if (!cs_match) begin
            err_checksum <= 1'b1;
            state        <= S_ERR;
          end else if (hdr_bad) begin
            err_hdr <= 1'b1;
            state   <= S_ERR;
          end else begin
            nwords <= hdr_len[23:1];
            dcnt   <= '0;
`ifdef INPKT_CHECKSUM_INTERVAL_EN
            int_cnt <= '0;
`endif
            state  <= S_HDR_OUT;
          end
        end
        S_HDR_OUT: if (out_free) begin
          if (idx == 3'(HDR_WORDS - 1)) begin
            idx   <= '0;
            state <= S_DATA;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_DATA: if (in_take) begin
          dcnt <= dcnt + 23'd1;
          if (data_last) begin
            state <= S_DAT_CS0;
`ifdef INPKT_CHECKSUM_INTERVAL_EN
            mid   <= 1'b0;
`endif
          end
`ifdef INPKT_CHECKSUM_INTERVAL_EN
          else if (int_cnt == 23'(INTERVAL_WORDS - 1)) begin
            mid     <= 1'b1;
            int_cnt <= '0;
            state   <= S_DAT_CS0;
          end else begin
            int_cnt <= int_cnt + 23'd1;
          end
`endif
        end
        S_DAT_CS0: if (in_take) begin
          if (!cs_match) begin
            err_checksum <= 1'b1;
            state        <= S_ERR;
          end else begin
            state <= S_DAT_CS1;
          end
        end
        S_DAT_CS1: if (in_take) begin
          if (!cs_match) begin
            err_checksum <= 1'b1;
            state        <= S_ERR;
          end else begin
`ifdef INPKT_CHECKSUM_INTERVAL_EN
            state <= mid ? S_DATA : S_HDR;
`else
            state <= S_HDR;
`endif
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: doc/inpkt_checksum.md
Name: inpkt_checksum

Overview:
Receive-side counterpart of the output checksum inserter. It sits between the host input FIFO and the input packet parser. It takes a 16-bit word stream of {header, header checksum, data, data checksum} and verifies both checksums. It strips the checksum words and forwards header+data downstream with packet-boundary flags. The header is held back until its checksum verifies; data streams through, and a data-checksum error is flagged at packet end.

Parameters:
PKT_VERSION, 2, required header version byte
PKT_MAX_LEN, 16384, maximum data length in bytes
PKT_CHECKSUM_INTERVAL, 448, data bytes between intermediate checksums (only with optional feature)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
din  in  16  input word
wr_en  in  1  write strobe; word accepted when wr_en & ~full
full  out  1  input register occupied
dout  out  16  output word
pkt_new_out  out  1  qualifies dout: first header word
pkt_end_out  out  1  qualifies dout: last data word
rd_en  in  1  downstream read; honoured when ~empty
empty  out  1  output register empty
err_hdr  out  1  sticky: bad version, length 0, odd or > PKT_MAX_LEN
err_checksum  out  1  sticky: header or data checksum mismatch

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high on RST. It clears full, pkt_new_out, pkt_end_out, err_hdr and err_checksum, sets empty=1, state=HDR, and clears the counters and accumulator.
- Header is 5 little-endian words:
  - w0={type,ver}
  - w1=reserved
  - w2=len[15:0]
  - w3={rsvd,len[23:16]}
  - w4=id
- Checksum: 32-bit wrapping sum of pairs {w[2k+1],w[2k]}. A trailing odd word is added zero-extended. The sum is bitwise inverted and arrives as two words, low half first.
- Input side: one-entry register, same handshake as a FWFT FIFO write port. Output side: one-entry register. A word can move from input to output in the same cycle that the output is read, so throughput is 1 word/clk.
- States:
  - HDR: accept 5 words into hdr_buf[0..4] and accumulate. After w4 -> HDR_CS0.
  - HDR_CS0 / HDR_CS1: accept the low/high checksum word and compare each against ~sum half.
    - Any mismatch -> ERR with err_checksum=1.
    - Else, bad ver/len -> ERR with err_hdr=1.
    - Else -> HDR_OUT.
  - HDR_OUT: emit hdr_buf[0..4] without consuming input. pkt_new_out=1 on word 0. Then clear the accumulator and the pair phase -> DATA.
  - DATA: pass words through and accumulate. The word completing len/2 words gets pkt_end_out=1 -> DAT_CS0.
  - DAT_CS0 / DAT_CS1: verify as for the header.
    - Mismatch -> ERR with err_checksum=1. The preceding data have already been delivered.
    - Match -> HDR.
  - ERR: terminal until RST. full=0, input words accepted and discarded, no output writes. The output register still drains.
- Latency:
  - First header word is presented 1 clk after the second header checksum word is accepted, provided the output register is free.
  - A data word is presented 1 clk after acceptance.
- Accumulator wrap-around is modulo 2^32. Checksum words are never forwarded.
- Back-to-back packets: HDR is entered the cycle after the DAT_CS1 word is accepted, with no bubble on input.
- While the output register is stalled (~empty & ~rd_en), the input register holds and full stays 1.

Optional Feature:
INPKT_CHECKSUM_INTERVAL_EN
- Defined: DATA also expects a 2-word checksum after every PKT_CHECKSUM_INTERVAL data bytes that is not the packet end. Each is verified as above; the accumulator is cleared after a match and DATA resumes.
- Undefined: data checksum appears only at packet end.

Decomposition:
- Shared package: header word offsets, header length (5 words), state encodings, PKT_VERSION default.
- One natural sub-module: inpkt_checksum_acc (pair latch + 32-bit accumulator + compare; clear/add/check strobes), reused for header and data.

Test Plan:
- Good packet:
  - Input: 0x0102,0,0x0004,0,0x0005, FEF4,FFFF, 0x1111,0x2222, EEEE,DDDD.
  - Output: 0x0102(pkt_new),0,4,0,5,0x1111,0x2222(pkt_end); no errors.
- Header checksum corrupted:
  - Input: as the good packet but with FEF5 in place of FEF4.
  - Response: err_checksum=1, no output words, later input discarded.
- Data checksum corrupted:
  - Input: as the good packet but with EEEF in place of EEEE.
  - Response: all 7 words delivered, err_checksum=1 after the DDDD word.
- Bad header:
  - len=3, with the header checksum recomputed accordingly -> err_hdr=1.
  - ver=1 -> err_hdr=1.
- Stall and back-to-back:
  - Stimulus: two good packets, rd_en toggled 1/0 randomly, RST pulsed mid-DATA on a third packet.
  - Response: exact sequence for both packets, no loss or duplication. After RST, empty=1, state=HDR and a fresh packet passes.
- Checksum interval (with INPKT_CHECKSUM_INTERVAL_EN):
  - Stimulus: len=900 with a correct checksum after bytes 448 and 896.
  - Response: 450 data words out, no error.
